// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding, frame defaults and pixel conversion for the camera write path
package cam_pkg;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 144;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } cam_state_e;

  // High byte arrives first: R[4:0] G[5:3] | G[2:0] B[4:0]; keep R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    logic unused_bits;
    unused_bits = ^{hi[4:3], lo[7:5], lo[2:0]};
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_input_sync.sv
// rtl/cam_input_sync.sv - aligned 2-flop synchronizer and edge detect for the camera pins
module cam_input_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pclk_i,
  input  logic       href_i,
  input  logic       vsync_i,
  input  logic [7:0] data_i,
  output logic       pclk_rise_o,
  output logic       href_o,
  output logic       href_fall_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic [7:0] data_o
);

  localparam int P_PCLK  = 8;
  localparam int P_HREF  = 9;
  localparam int P_VSYNC = 10;

  logic [10:0] sync1_q, sync2_q;
  logic [2:0]  hist_q;
  logic        pclk_rise_q, href_q, href_fall_q, vsync_rise_q, vsync_fall_q;
  logic [7:0]  data_q;

  // Edge flags and data are registered together so the byte always pairs with its strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      hist_q       <= '0;
      pclk_rise_q  <= 1'b0;
      href_q       <= 1'b0;
      href_fall_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      vsync_fall_q <= 1'b0;
      data_q       <= '0;
    end else begin
      sync1_q      <= {vsync_i, href_i, pclk_i, data_i};
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q[P_VSYNC:P_PCLK];
      pclk_rise_q  <= sync2_q[P_PCLK] & ~hist_q[0];
      href_q       <= sync2_q[P_HREF];
      href_fall_q  <= ~sync2_q[P_HREF] & hist_q[1];
      vsync_rise_q <= sync2_q[P_VSYNC] & ~hist_q[2];
      vsync_fall_q <= ~sync2_q[P_VSYNC] & hist_q[2];
      data_q       <= sync2_q[7:0];
    end
  end

  assign pclk_rise_o  = pclk_rise_q;
  assign href_o       = href_q;
  assign href_fall_o  = href_fall_q;
  assign vsync_rise_o = vsync_rise_q;
  assign vsync_fall_o = vsync_fall_q;
  assign data_o       = data_q;

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - captures RGB565 camera frames and writes RGB332 pixels row-major into the frame buffer
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int WIDTH  = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAPTURE_EN,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_END    = XW'(WIDTH);
  localparam logic [YW-1:0]     Y_END    = YW'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  logic       pclk_rise, href_lvl, href_fall, vsync_rise, vsync_fall;
  logic [7:0] cam_data;

  cam_input_sync u_sync (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .pclk_i       (CAM_PCLK),
    .href_i       (CAM_HREF),
    .vsync_i      (CAM_VSYNC),
    .data_i       (CAM_DATA),
    .pclk_rise_o  (pclk_rise),
    .href_o       (href_lvl),
    .href_fall_o  (href_fall),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .data_o       (cam_data)
  );

  cam_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic              ovf_q, ovf_d;
  logic              err_seen_q, err_seen_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              line_bad;

  // Same-cycle events are applied in order byte -> href_fall -> vsync_rise, each seeing the previous result.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    ovf_d      = ovf_q;
    err_seen_d = err_seen_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    line_bad   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CAPTURE_EN) state_d = ST_WAIT_FRAME;
      end

      ST_WAIT_FRAME: begin
        if (!CAPTURE_EN) begin
          state_d = ST_IDLE;
        end else if (vsync_fall) begin
          state_d    = ST_ACTIVE;
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          phase_d    = 1'b0;
          ovf_d      = 1'b0;
          err_seen_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (pclk_rise && href_lvl) begin
          if (!phase_q) begin
            hi_d    = cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < X_END && y_q < Y_END) begin
              w_en_d   = 1'b1;
              w_addr_d = row_base_q + ADDR_W'(x_q);
              w_data_d = rgb565_to_rgb332(hi_q, cam_data);
            end
            // x stops at WIDTH; ovf remembers that the line carried more pixels than that.
            if (x_q == X_END) ovf_d = 1'b1;
            else              x_d   = x_q + 1'b1;
          end
        end

        if (href_fall) begin
          line_bad = (x_d != X_END) || phase_d || ovf_d;
          if (x_d != '0 && y_q < Y_END) begin
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + ROW_STEP;
          end
          x_d     = '0;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end

        // At most one error pulse per frame, whichever check trips first.
        if (line_bad && !err_seen_d) begin
          err_d      = 1'b1;
          err_seen_d = 1'b1;
        end

        if (vsync_rise) begin
          if (y_d == Y_END && !err_seen_d) begin
            done_d = 1'b1;
          end else if (!err_seen_d) begin
            err_d      = 1'b1;
            err_seen_d = 1'b1;
          end
          state_d = CAPTURE_EN ? ST_WAIT_FRAME : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      err_seen_q <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      ovf_q      <= ovf_d;
      err_seen_q <= err_seen_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign W_EN       = w_en_q;
  assign W_ADDR     = w_addr_q;
  assign W_DATA     = w_data_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - scoreboard bench for cam_frame_writer on a reduced 16x12 frame
module tb_cam_frame_writer;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CAPTURE_EN = 1'b0;
  logic          CAM_PCLK = 1'b0;
  logic          CAM_HREF = 1'b0;
  logic          CAM_VSYNC = 1'b0;
  logic [7:0]    CAM_DATA = 8'h00;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          FRAME_DONE, FRAME_ERR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_wr[$];
  logic [7:0]  exp_ev[$];
  bit expect_en = 1'b1;

  logic [7:0] tab_hi[4] = '{8'hF8, 8'h07, 8'h00, 8'hA5};
  logic [7:0] tab_lo[4] = '{8'h00, 8'hE0, 8'h1F, 8'h5A};
  logic [7:0] tab_px[4] = '{8'hE0, 8'h1C, 8'h03, 8'hB7};

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CAPTURE_EN (CAPTURE_EN),
    .CAM_PCLK   (CAM_PCLK),
    .CAM_HREF   (CAM_HREF),
    .CAM_VSYNC  (CAM_VSYNC),
    .CAM_DATA   (CAM_DATA),
    .W_EN       (W_EN),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (W_EN) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_write: got addr %0d data %0h, expected no write", W_ADDR, W_DATA);
        end else begin
          check("write_addr_data", 32'({W_ADDR, W_DATA}), exp_wr.pop_front());
        end
        check("write_addr_bound", 32'(W_ADDR < W * H), 32'd1);
      end
      if (FRAME_DONE || FRAME_ERR) begin
        check("done_err_exclusive", 32'(FRAME_DONE & FRAME_ERR), 32'd0);
        if (exp_ev.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_event: got done=%0d err=%0d, expected none", FRAME_DONE, FRAME_ERR);
        end else begin
          check("frame_event", FRAME_DONE ? 32'h44 : 32'h45, 32'(exp_ev.pop_front()));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_en"}, 32'(W_EN), 32'd0);
    check({tag, "_w_addr"}, 32'(W_ADDR), 32'd0);
    check({tag, "_w_data"}, 32'(W_DATA), 32'd0);
    check({tag, "_done"}, 32'(FRAME_DONE), 32'd0);
    check({tag, "_err"}, 32'(FRAME_ERR), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    CAM_DATA = b;
    #40 CAM_PCLK = 1'b1;
    #40 CAM_PCLK = 1'b0;
  endtask

  task automatic send_line(input int y, input int npx, input bit push_err);
    int k;
    CAM_HREF = 1'b1;
    for (int x = 0; x < npx; x++) begin
      k = (x + y) % 4;
      send_byte(tab_hi[k]);
      if (expect_en && x < W && y < H) exp_wr.push_back(32'({AW'(y * W + x), tab_px[k]}));
      send_byte(tab_lo[k]);
    end
    if (push_err) exp_ev.push_back("E");
    CAM_HREF = 1'b0;
    #160;
  endtask

  // end_ev: "D", "E" or 0 for the event expected at the closing vsync rise.
  task automatic send_frame(input int nlines, input int npx, input int short_y, input int short_px,
                            input int err_y, input int stop_y, input int reset_y, input logic [7:0] end_ev);
    CAM_VSYNC = 1'b1;
    #200 CAM_VSYNC = 1'b0;
    #200;
    for (int y = 0; y < nlines; y++) begin
      if (y == stop_y) CAPTURE_EN = 1'b0;
      if (y == reset_y) begin
        RESET_N = 1'b0;
        exp_wr.delete();
        exp_ev.delete();
        #1 check_reset_outputs("midframe_reset");
        #39 RESET_N = 1'b1;
        expect_en = 1'b0;
      end
      send_line(y, (y == short_y) ? short_px : npx, expect_en && (y == err_y));
    end
    if (end_ev != 8'h00) exp_ev.push_back(end_ev);
    CAM_VSYNC = 1'b1;
    #400;
  endtask

  initial begin
    #3 check_reset_outputs("reset");
    #40 RESET_N = 1'b1;
    CAPTURE_EN = 1'b1;
    #100 check("busy_wait_frame", 32'(BUSY), 32'd1);

    send_frame(H, W, -1, 0, -1, -1, -1, "D");        // nominal frame
    send_frame(H, W, 5, 10, 5, -1, -1, 8'h00);       // short line 5
    send_frame(H + 2, W + 4, -1, 0, 0, -1, -1, 8'h00); // oversize 20x14
    send_frame(H, W, -1, 0, -1, -1, 7, 8'h00);       // reset at line 7
    expect_en = 1'b1;
    send_frame(H, W, -1, 0, -1, -1, -1, "D");        // restarts at address 0
    send_frame(H, W, -1, 0, -1, 8, -1, "D");         // stop request at line 8
    check("busy_after_stop", 32'(BUSY), 32'd0);
    expect_en = 1'b0;
    send_frame(H, W, -1, 0, -1, -1, -1, 8'h00);      // idle: no writes
    check("busy_idle_frame", 32'(BUSY), 32'd0);

    #400;
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("events_outstanding", 32'(exp_ev.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
